// File: rtl/ctrl_unit_pipe.sv
// Registered RV32IM decode stage: OP/FUN3/FUN7 -> EX/MEM/WB control bundle, sequencing MUL/DIV occupancy.
// Latency: 1 cycle from accept to registered bundle; M ops hold BUSY for L-1 further cycles.
// Backpressure: STALL_IN holds all state; STALL_OUT = STALL_IN | BUSY holds IF/ID; FLUSH overrides everything.
module ctrl_unit_pipe #(
    parameter int MUL_LAT  = 3,
    parameter int DIV_LAT  = 34,
    parameter bit ENABLE_M = 1'b1,
    parameter int CNT_W    = 6
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       INSTR_VALID,
    input  logic [6:0] OP,
    input  logic [2:0] FUN3,
    input  logic [6:0] FUN7,
    input  logic       STALL_IN,
    input  logic       FLUSH,
    output logic [4:0] ALU_OP,
    output logic [2:0] MEM_READ,
    output logic [2:0] MEM_WRITE,
    output logic [2:0] IMMI_SEL,
    output logic [1:0] MEM_TO_REG,
    output logic [1:0] ALU_SOURCE,
    output logic       REG_WRITE,
    output logic       BRANCH,
    output logic       PC_SEL,
    output logic       VALID_OUT,
    output logic       ILLEGAL,
    output logic       BUSY,
    output logic       STALL_OUT
);

    typedef struct packed {
        logic [4:0] alu_op;
        logic [2:0] mem_read;
        logic [2:0] mem_write;
        logic [2:0] immi_sel;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_source;
        logic       reg_write;
        logic       branch;
        logic       pc_sel;
        logic       valid;
        logic       illegal;
    } ctrl_t;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    localparam ctrl_t BUBBLE = '0;
    // Counter load values: the issue edge itself is the first of the L cycles.
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
    localparam bit MUL_MC = (MUL_LAT > 1);
    localparam bit DIV_MC = (DIV_LAT > 1);

    ctrl_t              ctrl_q, ctrl_d, dec;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_m, bad;

    // Pure decode of the incoming instruction; illegal encodings collapse to a marked bubble.
    always_comb begin
        dec       = BUBBLE;
        dec.valid = 1'b1;
        is_m      = 1'b0;
        bad       = 1'b0;
        case (OP)
            7'b0110011: begin
                dec.reg_write = 1'b1;
                case (FUN7)
                    7'b0000000: dec.alu_op = {2'b00, FUN3};
                    7'b0100000: begin
                        if (FUN3 == 3'b000)      dec.alu_op = 5'b10000;
                        else if (FUN3 == 3'b101) dec.alu_op = 5'b10101;
                        else                     bad = 1'b1;
                    end
                    7'b0000001: begin
                        if (ENABLE_M) begin
                            dec.alu_op = {2'b11, FUN3};
                            is_m       = 1'b1;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                    default: bad = 1'b1;
                endcase
            end
            7'b0010011: begin
                dec.alu_source = 2'b01;
                dec.immi_sel   = 3'b001;
                dec.reg_write  = 1'b1;
                dec.alu_op     = {2'b00, FUN3};
                // FUN7 is only an opcode extension for the shift-immediates.
                if (FUN3 == 3'b001 && FUN7 != 7'b0000000) bad = 1'b1;
                if (FUN3 == 3'b101) begin
                    if (FUN7 == 7'b0100000)      dec.alu_op = 5'b10101;
                    else if (FUN7 != 7'b0000000) bad = 1'b1;
                end
            end
            7'b0000011: begin
                if (FUN3 == 3'b011 || FUN3[2:1] == 2'b11) bad = 1'b1;
                dec.mem_read   = {FUN3[2], FUN3[1:0] + 2'd1};
                dec.mem_to_reg = 2'b01;
                dec.alu_source = 2'b01;
                dec.immi_sel   = 3'b001;
                dec.reg_write  = 1'b1;
            end
            7'b0100011: begin
                if (FUN3[2] || FUN3[1:0] == 2'b11) bad = 1'b1;
                dec.mem_write  = {1'b0, FUN3[1:0] + 2'd1};
                dec.alu_source = 2'b01;
                dec.immi_sel   = 3'b010;
            end
            7'b1100011: begin
                if (FUN3[2:1] == 2'b01) bad = 1'b1;
                dec.branch   = 1'b1;
                dec.immi_sel = 3'b011;
            end
            7'b1101111: begin
                dec.pc_sel     = 1'b1;
                dec.mem_to_reg = 2'b10;
                dec.immi_sel   = 3'b101;
                dec.alu_source = 2'b10;
                dec.reg_write  = 1'b1;
            end
            7'b1100111: begin
                if (FUN3 != 3'b000) bad = 1'b1;
                dec.pc_sel     = 1'b1;
                dec.mem_to_reg = 2'b10;
                dec.immi_sel   = 3'b001;
                dec.alu_source = 2'b01;
                dec.reg_write  = 1'b1;
            end
            7'b0110111: begin
                dec.immi_sel   = 3'b100;
                dec.alu_source = 2'b01;
                dec.reg_write  = 1'b1;
            end
            7'b0010111: begin
                dec.immi_sel   = 3'b100;
                dec.alu_source = 2'b10;
                dec.reg_write  = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            dec         = BUBBLE;
            dec.valid   = 1'b1;
            dec.illegal = 1'b1;
            is_m        = 1'b0;
        end
    end

    // Next state: FLUSH > STALL_IN > WAIT countdown > accept.
    always_comb begin
        ctrl_d  = ctrl_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (FLUSH) begin
            ctrl_d  = BUBBLE;
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (STALL_IN) begin
            // Everything holds, including the countdown.
            ctrl_d = ctrl_q;
        end else if (state_q == ST_WAIT) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                ctrl_d  = BUBBLE;
                state_d = ST_IDLE;
            end else begin
                // Keep ALU_OP steering the unit, but nothing downstream may commit twice.
                ctrl_d.valid     = 1'b0;
                ctrl_d.reg_write = 1'b0;
                ctrl_d.mem_read  = 3'b000;
                ctrl_d.mem_write = 3'b000;
            end
        end else if (INSTR_VALID) begin
            ctrl_d = dec;
            if (is_m && (FUN3[2] ? DIV_MC : MUL_MC)) begin
                state_d = ST_WAIT;
                cnt_d   = FUN3[2] ? DIV_CNT : MUL_CNT;
            end
        end else begin
            ctrl_d = BUBBLE;
        end
    end

    // State and bundle registers; reset aborts any op in flight.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ctrl_q  <= BUBBLE;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ALU_OP     = ctrl_q.alu_op;
    assign MEM_READ   = ctrl_q.mem_read;
    assign MEM_WRITE  = ctrl_q.mem_write;
    assign IMMI_SEL   = ctrl_q.immi_sel;
    assign MEM_TO_REG = ctrl_q.mem_to_reg;
    assign ALU_SOURCE = ctrl_q.alu_source;
    assign REG_WRITE  = ctrl_q.reg_write;
    assign BRANCH     = ctrl_q.branch;
    assign PC_SEL     = ctrl_q.pc_sel;
    assign VALID_OUT  = ctrl_q.valid;
    assign ILLEGAL    = ctrl_q.illegal;
    assign BUSY       = (state_q == ST_WAIT);
    assign STALL_OUT  = STALL_IN | BUSY;

endmodule

// File: tb/tb_ctrl_unit_pipe.sv
// Bench for ctrl_unit_pipe: scoreboard of expected output vectors, popped one cycle after stimulus.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: STALL_IN / FLUSH driven explicitly by the scenario tasks.
module tb_ctrl_unit_pipe;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;
    localparam logic [6:0] F7_M    = 7'b0000001;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic       CLK = 1'b0;
    logic       RESET, INSTR_VALID, STALL_IN, FLUSH;
    logic [6:0] OP, FUN7;
    logic [2:0] FUN3;

    logic [4:0] alu_op, n_alu_op;
    logic [2:0] mem_read, mem_write, immi_sel, n_mem_read, n_mem_write, n_immi_sel;
    logic [1:0] mem_to_reg, alu_source, n_mem_to_reg, n_alu_source;
    logic       reg_write, branch, pc_sel, valid_out, illegal, busy, stall_out;
    logic       n_reg_write, n_branch, n_pc_sel, n_valid_out, n_illegal, n_busy, n_stall_out;

    int checks = 0;
    int errors = 0;
    logic [23:0] sb_q[$];

    always #5 CLK = ~CLK;

    ctrl_unit_pipe #(.MUL_LAT(3), .DIV_LAT(34), .ENABLE_M(1'b1), .CNT_W(6)) u_dut (
        .CLK(CLK), .RESET(RESET), .INSTR_VALID(INSTR_VALID), .OP(OP), .FUN3(FUN3), .FUN7(FUN7),
        .STALL_IN(STALL_IN), .FLUSH(FLUSH),
        .ALU_OP(alu_op), .MEM_READ(mem_read), .MEM_WRITE(mem_write), .IMMI_SEL(immi_sel),
        .MEM_TO_REG(mem_to_reg), .ALU_SOURCE(alu_source), .REG_WRITE(reg_write), .BRANCH(branch),
        .PC_SEL(pc_sel), .VALID_OUT(valid_out), .ILLEGAL(illegal), .BUSY(busy), .STALL_OUT(stall_out)
    );

    ctrl_unit_pipe #(.MUL_LAT(3), .DIV_LAT(34), .ENABLE_M(1'b0), .CNT_W(6)) u_nom (
        .CLK(CLK), .RESET(RESET), .INSTR_VALID(INSTR_VALID), .OP(OP), .FUN3(FUN3), .FUN7(FUN7),
        .STALL_IN(STALL_IN), .FLUSH(FLUSH),
        .ALU_OP(n_alu_op), .MEM_READ(n_mem_read), .MEM_WRITE(n_mem_write), .IMMI_SEL(n_immi_sel),
        .MEM_TO_REG(n_mem_to_reg), .ALU_SOURCE(n_alu_source), .REG_WRITE(n_reg_write), .BRANCH(n_branch),
        .PC_SEL(n_pc_sel), .VALID_OUT(n_valid_out), .ILLEGAL(n_illegal), .BUSY(n_busy), .STALL_OUT(n_stall_out)
    );

    // Expected-vector builder: {ALU_OP, MEM_READ, MEM_WRITE, IMMI_SEL, MEM_TO_REG, ALU_SOURCE, RW, BR, PC, V, IL, BUSY}
    function automatic logic [23:0] mk(input logic [4:0] alu, input logic [2:0] mr, input logic [2:0] mw,
                                       input logic [2:0] imm, input logic [1:0] m2r, input logic [1:0] src,
                                       input logic rw, input logic br, input logic pc, input logic v,
                                       input logic il, input logic bsy);
        return {alu, mr, mw, imm, m2r, src, rw, br, pc, v, il, bsy};
    endfunction

    function automatic logic [23:0] obs();
        return {alu_op, mem_read, mem_write, immi_sel, mem_to_reg, alu_source,
                reg_write, branch, pc_sel, valid_out, illegal, busy};
    endfunction

    function automatic logic [23:0] obs_nom();
        return {n_alu_op, n_mem_read, n_mem_write, n_immi_sel, n_mem_to_reg, n_alu_source,
                n_reg_write, n_branch, n_pc_sel, n_valid_out, n_illegal, n_busy};
    endfunction

    task automatic set_in(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        INSTR_VALID = v;
        OP          = op;
        FUN3        = f3;
        FUN7        = f7;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [23:0] e;
        RESET = 1'b1; STALL_IN = 1'b0; FLUSH = 1'b0;
        set_in(1'b0, 7'd0, 3'd0, 7'd0);
        tick();
        sb_q.push_back(24'd0);
        e = sb_q.pop_front();
        checks++;
        if (obs() !== e || stall_out !== 1'b0) begin
            errors++;
            $display("FAIL reset: got %h/%b want %h/0", obs(), stall_out, e);
        end
        #2 RESET = 1'b0;
    endtask

    task automatic test_decode();
        logic [6:0]  t_op[11];
        logic [2:0]  t_f3[11];
        logic [6:0]  t_f7[11];
        logic        t_v[11];
        logic [23:0] e;
        t_op = '{OP_R, OP_R, OP_LD, OP_ST, OP_JAL, OP_LUI, OP_BR, OP_AUI, OP_R, 7'b1111111, OP_I};
        t_f3 = '{3'b000, 3'b101, 3'b101, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b101};
        t_f7 = '{7'd0, F7_ALT, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, F7_ALT};
        t_v  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 11; i++) begin
            set_in(t_v[i], t_op[i], t_f3[i], t_f7[i]);
            case (i)
                0:  sb_q.push_back(mk(5'b00000, 3'b000, 3'b000, 3'b000, 2'b00, 2'b00, 1, 0, 0, 1, 0, 0)); // ADD
                1:  sb_q.push_back(mk(5'b10101, 3'b000, 3'b000, 3'b000, 2'b00, 2'b00, 1, 0, 0, 1, 0, 0)); // SRA
                2:  sb_q.push_back(mk(5'b00000, 3'b110, 3'b000, 3'b001, 2'b01, 2'b01, 1, 0, 0, 1, 0, 0)); // LHU
                3:  sb_q.push_back(mk(5'b00000, 3'b000, 3'b011, 3'b010, 2'b00, 2'b01, 0, 0, 0, 1, 0, 0)); // SW
                4:  sb_q.push_back(mk(5'b00000, 3'b000, 3'b000, 3'b101, 2'b10, 2'b10, 1, 0, 1, 1, 0, 0)); // JAL
                5:  sb_q.push_back(mk(5'b00000, 3'b000, 3'b000, 3'b100, 2'b00, 2'b01, 1, 0, 0, 1, 0, 0)); // LUI
                6:  sb_q.push_back(mk(5'b00000, 3'b000, 3'b000, 3'b011, 2'b00, 2'b00, 0, 1, 0, 1, 0, 0)); // BEQ
                7:  sb_q.push_back(mk(5'b00000, 3'b000, 3'b000, 3'b100, 2'b00, 2'b10, 1, 0, 0, 1, 0, 0)); // AUIPC
                8:  sb_q.push_back(24'd0);                                                               // bubble
                9:  sb_q.push_back(mk(5'b00000, 3'b000, 3'b000, 3'b000, 2'b00, 2'b00, 0, 0, 0, 1, 1, 0)); // illegal
                default: sb_q.push_back(mk(5'b10101, 3'b000, 3'b000, 3'b001, 2'b00, 2'b01, 1, 0, 0, 1, 0, 0)); // SRAI
            endcase
            tick();
            e = sb_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL decode[%0d]: got %h want %h", i, obs(), e);
            end
        end
        set_in(1'b0, 7'd0, 3'd0, 7'd0);
        tick();
    endtask

    // MUL: BUSY/STALL_OUT for exactly 2 cycles; optional one-cycle STALL_IN mid-WAIT stretches it to 3.
    task automatic test_mul(input logic with_stall);
        logic [23:0] e;
        int          n;
        logic        s_exp;
        set_in(1'b1, OP_R, 3'b000, F7_M);
        sb_q.push_back(mk(5'b11000, 3'b000, 3'b000, 3'b000, 2'b00, 2'b00, 1, 0, 0, 1, 0, 1));
        if (with_stall)
            sb_q.push_back(mk(5'b11000, 3'b000, 3'b000, 3'b000, 2'b00, 2'b00, 1, 0, 0, 1, 0, 1));
        sb_q.push_back(mk(5'b11000, 3'b000, 3'b000, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1));
        sb_q.push_back(24'd0);
        sb_q.push_back(mk(5'b00000, 3'b000, 3'b000, 3'b000, 2'b00, 2'b00, 1, 0, 0, 1, 0, 0)); // ADD after
        n = with_stall ? 5 : 4;
        for (int c = 0; c < n; c++) begin
            tick();
            // ADD is presented throughout WAIT and must be ignored until the op retires.
            set_in(1'b1, OP_R, 3'b000, 7'd0);
            STALL_IN = (with_stall && c == 0);
            #1;
            e = sb_q.pop_front();
            s_exp = e[0] | STALL_IN;
            checks++;
            if (obs() !== e || stall_out !== s_exp) begin
                errors++;
                $display("FAIL mul%0s[%0d]: got %h/%b want %h/%b", with_stall ? "_stall" : "", c,
                         obs(), stall_out, e, s_exp);
            end
        end
        STALL_IN = 1'b0;
        set_in(1'b0, 7'd0, 3'd0, 7'd0);
        tick();
    endtask

    task automatic test_div_flush();
        logic [23:0] e;
        set_in(1'b1, OP_R, 3'b100, F7_M);
        sb_q.push_back(mk(5'b11100, 3'b000, 3'b000, 3'b000, 2'b00, 2'b00, 1, 0, 0, 1, 0, 1));
        for (int c = 0; c < 4; c++)
            sb_q.push_back(mk(5'b11100, 3'b000, 3'b000, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1));
        sb_q.push_back(24'd0);
        sb_q.push_back(mk(5'b00001, 3'b000, 3'b000, 3'b000, 2'b00, 2'b00, 1, 0, 0, 1, 0, 0)); // SLL
        for (int c = 0; c < 7; c++) begin
            tick();
            set_in(1'b1, OP_R, 3'b001, 7'd0);
            FLUSH = (c == 4);
            e = sb_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL div_flush[%0d]: got %h want %h", c, obs(), e);
            end
        end
        FLUSH = 1'b0;
        set_in(1'b0, 7'd0, 3'd0, 7'd0);
        tick();
    endtask

    task automatic test_no_m();
        logic [23:0] e;
        set_in(1'b1, OP_R, 3'b000, F7_M);
        sb_q.push_back(mk(5'b00000, 3'b000, 3'b000, 3'b000, 2'b00, 2'b00, 0, 0, 0, 1, 1, 0));
        sb_q.push_back(24'd0);
        for (int c = 0; c < 2; c++) begin
            tick();
            set_in(1'b0, 7'd0, 3'd0, 7'd0);
            e = sb_q.pop_front();
            checks++;
            if (obs_nom() !== e || n_stall_out !== 1'b0) begin
                errors++;
                $display("FAIL no_m[%0d]: got %h/%b want %h/0", c, obs_nom(), n_stall_out, e);
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_div();
        logic [23:0] e;
        set_in(1'b1, OP_R, 3'b110, F7_M);
        tick();
        set_in(1'b0, 7'd0, 3'd0, 7'd0);
        repeat (13) tick();           // countdown now at 20
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_div_busy: got %b want 1", busy);
        end
        RESET = 1'b1;
        #1;
        sb_q.push_back(24'd0);
        e = sb_q.pop_front();
        checks++;
        if (obs() !== e || stall_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_div_async: got %h/%b want %h/0", obs(), stall_out, e);
        end
        tick();
        RESET = 1'b0;
        sb_q.push_back(24'd0);
        tick();
        e = sb_q.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL rst_div_after: got %h want %h", obs(), e);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] e;
        set_in(1'b1, OP_R, 3'b000, F7_ALT);   // SUB
        sb_q.push_back(mk(5'b10000, 3'b000, 3'b000, 3'b000, 2'b00, 2'b00, 1, 0, 0, 1, 0, 0));
        tick();
        e = sb_q.pop_front();
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL b2b_sub: got %h want %h", obs(), e); end
        set_in(1'b1, OP_LD, 3'b010, 7'd0);    // LW
        sb_q.push_back(mk(5'b00000, 3'b011, 3'b000, 3'b001, 2'b01, 2'b01, 1, 0, 0, 1, 0, 0));
        tick();
        e = sb_q.pop_front();
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL b2b_lw: got %h want %h", obs(), e); end
        set_in(1'b1, OP_JALR, 3'b000, 7'd0);  // JALR
        sb_q.push_back(mk(5'b00000, 3'b000, 3'b000, 3'b001, 2'b10, 2'b01, 1, 0, 1, 1, 0, 0));
        tick();
        e = sb_q.pop_front();
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL b2b_jalr: got %h want %h", obs(), e); end
        set_in(1'b1, OP_LD, 3'b011, 7'd0);    // undefined load width
        sb_q.push_back(mk(5'b00000, 3'b000, 3'b000, 3'b000, 2'b00, 2'b00, 0, 0, 0, 1, 1, 0));
        tick();
        e = sb_q.pop_front();
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL b2b_ld011: got %h want %h", obs(), e); end
        set_in(1'b1, OP_ST, 3'b011, 7'd0);    // undefined store width
        sb_q.push_back(mk(5'b00000, 3'b000, 3'b000, 3'b000, 2'b00, 2'b00, 0, 0, 0, 1, 1, 0));
        tick();
        e = sb_q.pop_front();
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL b2b_st011: got %h want %h", obs(), e); end
        set_in(1'b0, 7'd0, 3'd0, 7'd0);
    endtask

    initial begin
        test_reset();
        test_decode();
        test_mul(1'b0);
        test_mul(1'b1);
        test_div_flush();
        test_no_m();
        test_reset_mid_div();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
